// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: address bus width, access-width and FSM state encodings.
package mem_ctrl_pkg;

  localparam int INST_ADDR_BUS = 32;
  typedef logic [INST_ADDR_BUS-1:0] inst_addr_t;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } width_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Encoding 3 is treated as a full word.
  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      WIDTH_BYTE: return 3'd1;
      WIDTH_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating load/store (priority) and instruction fetch; read done T+n+2, write done T+n+1.
// rdy_in=0 freezes all state and suppresses ram_wr; requests are held by the requester until their done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     if_req,
  input  logic [INST_ADDR_BUS-1:0] if_addr,
  output logic                     if_done,
  output logic [31:0]              if_inst,
  input  logic                     mem_req,
  input  logic                     mem_we,
  input  logic [1:0]               mem_width,
  input  logic [INST_ADDR_BUS-1:0] mem_addr,
  input  logic [31:0]              mem_wdata,
  output logic                     mem_done,
  output logic [31:0]              mem_rdata,
  input  logic [7:0]               ram_din,
  output logic [7:0]               ram_dout,
  output logic [INST_ADDR_BUS-1:0] ram_a,
  output logic                     ram_wr,
  output logic                     busy
);

  state_e     state;
  logic [2:0] cnt;
  logic [2:0] n;
  logic [2:0] cnt_nxt;
  logic [1:0] bidx;
  inst_addr_t base;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [31:0] rbuf_nxt;
  logic        owner_mem;
  logic        wr_q;
  logic        blocked;
  logic        take_mem;
  logic        take_if;

  // No accept while any done is showing, so a held request is never re-taken
  // and a waiting fetch only starts the cycle after a load/store completes.
  assign blocked  = if_done | mem_done;
  assign take_mem = mem_req & ~blocked;
  assign take_if  = if_req & ~mem_req & ~blocked;

  assign cnt_nxt = cnt + 3'd1;
  assign bidx    = cnt[1:0] - 2'd1;
  assign ram_wr  = wr_q & rdy_in;

  // Byte arriving now belongs to the address issued one count earlier.
  always_comb begin
    rbuf_nxt = rbuf;
    if (cnt != 3'd0) rbuf_nxt[{bidx, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      n         <= 3'd0;
      base      <= '0;
      wdata     <= 32'd0;
      rbuf      <= 32'd0;
      owner_mem <= 1'b0;
      wr_q      <= 1'b0;
      busy      <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      ram_a     <= '0;
      ram_dout  <= 8'd0;
      if_inst   <= 32'd0;
      mem_rdata <= 32'd0;
    end else if (rdy_in) begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take_mem | take_if) begin
            owner_mem <= take_mem;
            base      <= take_mem ? mem_addr : if_addr;
            ram_a     <= take_mem ? mem_addr : if_addr;
            n         <= take_mem ? width_bytes(mem_width) : 3'd4;
            wdata     <= mem_wdata;
            cnt       <= 3'd0;
            rbuf      <= 32'd0;
            busy      <= 1'b1;
            if (take_mem & mem_we) begin
              state    <= ST_WRITE;
              wr_q     <= 1'b1;
              ram_dout <= mem_wdata[7:0];
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          rbuf <= rbuf_nxt;
          if (cnt == n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (owner_mem) begin
              mem_rdata <= rbuf_nxt;
              mem_done  <= 1'b1;
            end else begin
              if_inst <= rbuf_nxt;
              if_done <= 1'b1;
            end
          end else begin
            cnt   <= cnt_nxt;
            ram_a <= base + inst_addr_t'(cnt_nxt);
          end
        end
        ST_WRITE: begin
          if (cnt_nxt == n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            wr_q     <= 1'b0;
            mem_done <= 1'b1;
          end else begin
            cnt      <= cnt_nxt;
            ram_a    <= base + inst_addr_t'(cnt_nxt);
            ram_dout <= wdata[{cnt_nxt[1:0], 3'b000} +: 8];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM, transaction-level reference, directed cases and randomized traffic.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req, if_done, mem_req, mem_we, mem_done, ram_wr, busy;
  logic [31:0] if_addr, if_inst, mem_addr, mem_wdata, mem_rdata, ram_a;
  logic [1:0]  mem_width;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  ram_dout;
  int          checks = 0;
  int          passes = 0;
  bit          cmp_en = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Physical RAM (written by the DUT) and the reference image (written by the model).
  logic [7:0] ram  [logic [31:0]];
  logic [7:0] mimg [logic [31:0]];

  function automatic logic [7:0] finit(input logic [31:0] a);
    return a[7:0] ^ a[31:24] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_get(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return finit(a);
  endfunction
  function automatic logic [7:0] img_get(input logic [31:0] a);
    if (mimg.exists(a)) return mimg[a];
    return finit(a);
  endfunction
  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]  = d;
    mimg[a] = d;
  endtask

  // The RAM is part of the globally stalled system: it also freezes while rdy_in=0.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (ram_wr) ram[ram_a] = ram_dout;
      ram_din <= ram_get(ram_a);
    end
  end

  // Reference: one transaction at a time; el counts active cycles since accept.
  logic        m_act, m_we, m_mem, m_if_done, m_mem_done, m_blk;
  logic [31:0] m_base, m_wdata, m_inst, m_rdata, m_acc;
  int          m_n, m_el;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m_act = 0; m_if_done = 0; m_mem_done = 0; m_inst = 0; m_rdata = 0; m_el = 0;
      m_we = 0; m_mem = 0; m_base = 0; m_wdata = 0; m_n = 0;
    end else if (rdy_in) begin
      m_blk = m_if_done | m_mem_done;
      m_if_done = 0;
      m_mem_done = 0;
      if (m_act) begin
        if (m_we) begin
          mimg[m_base + 32'(m_el)] = m_wdata[8*m_el +: 8];
          m_el++;
          if (m_el == m_n) begin m_act = 0; m_mem_done = 1; end
        end else begin
          m_el++;
          if (m_el == m_n + 1) begin
            m_acc = 0;
            for (int i = 0; i < m_n; i++) m_acc |= 32'(img_get(m_base + 32'(i))) << (8*i);
            if (m_mem) begin m_rdata = m_acc; m_mem_done = 1; end
            else begin m_inst = m_acc; m_if_done = 1; end
            m_act = 0;
          end
        end
      end else if (!m_blk && (mem_req || if_req)) begin
        m_act   = 1;
        m_el    = 0;
        m_mem   = mem_req;
        m_we    = mem_req && mem_we;
        m_base  = mem_req ? mem_addr : if_addr;
        m_wdata = mem_wdata;
        m_n     = !mem_req ? 4 : (mem_width == 2'd0 ? 1 : (mem_width == 2'd1 ? 2 : 4));
      end
    end
  end

  always @(negedge clk_in) begin
    if (cmp_en && rst_in) begin
      chk("busy", busy, m_act);
      chk("if_done", if_done, m_if_done);
      chk("mem_done", mem_done, m_mem_done);
      chk("ram_wr", ram_wr, m_act && m_we && rdy_in);
      chk("if_inst", if_inst, m_inst);
      chk("mem_rdata", mem_rdata, m_rdata);
      if (m_act) chk("ram_a", ram_a, m_base + 32'(m_el));
      if (m_act && m_we) chk("ram_dout", ram_dout, m_wdata[8*m_el +: 8]);
    end
  end

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  logic [31:0] a_log [16];
  logic [7:0]  d_log [16];
  logic        w_log [16];

  task automatic wait_done(input bit is_mem, input int max, output int lat);
    lat = -1;
    for (int k = 1; k <= max; k++) begin
      step();
      a_log[k%16] = ram_a; d_log[k%16] = ram_dout; w_log[k%16] = ram_wr;
      if (is_mem ? mem_done : if_done) begin lat = k; break; end
    end
  endtask

  task automatic new_mem();
    mem_req   = 1;
    mem_we    = 1'($urandom_range(0, 1));
    mem_width = 2'($urandom_range(0, 3));
    mem_addr  = rand_addr();
    mem_wdata = $urandom;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return 32'h100 + 32'($urandom_range(0, 31));
      1:       return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      default: return 32'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [31:0] exp_a [4];
  int lat, lat2, wr_cnt;

  initial begin
    rst_in = 0; rdy_in = 1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
    mem_width = 0; mem_addr = 0; mem_wdata = 0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_busy", busy, 0);       chk("rst_ram_wr", ram_wr, 0);
    chk("rst_if_done", if_done, 0); chk("rst_mem_done", mem_done, 0);
    chk("rst_ram_a", ram_a, 0);     chk("rst_ram_dout", ram_dout, 0);
    chk("rst_if_inst", if_inst, 0); chk("rst_mem_rdata", mem_rdata, 0);

    // Word fetch, accepted on the first edge after reset release.
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    if_req = 1; if_addr = 32'h100;
    @(negedge clk_in);
    rst_in = 1; cmp_en = 1;
    wait_done(0, 12, lat);
    chk("fetch_latency", lat, 6);
    for (int k = 1; k <= 4; k++) chk("fetch_ram_a", a_log[k], 32'h100 + 32'(k - 1));
    chk("fetch_inst", if_inst, 32'h0000_0513);
    if_req = 0; step();

    // Byte store.
    mem_req = 1; mem_we = 1; mem_width = 0; mem_addr = 32'h20; mem_wdata = 32'hABCD_12EF;
    wait_done(1, 12, lat);
    chk("bstore_latency", lat, 2);
    wr_cnt = 0;
    for (int k = 1; k <= 2; k++) if (w_log[k]) wr_cnt++;
    chk("bstore_wr_cycles", wr_cnt, 1);
    chk("bstore_ram_a", a_log[1], 32'h20);
    chk("bstore_dout", d_log[1], 8'hEF);
    mem_req = 0; step();

    // Simultaneous fetch and half load; mem held through its done cycle.
    preload(32'h40, 8'h34); preload(32'h41, 8'h12);
    if_req = 1; if_addr = 32'h100;
    mem_req = 1; mem_we = 0; mem_width = 1; mem_addr = 32'h40;
    wait_done(1, 12, lat);
    chk("prio_mem_latency", lat, 4);
    chk("prio_mem_rdata", mem_rdata, 32'h0000_1234);
    chk("prio_if_not_done", if_done, 0);
    step();
    chk("prio_no_accept_in_done", busy, 0);
    mem_req = 0;
    wait_done(0, 12, lat2);
    chk("prio_fetch_latency", lat2, 6);
    chk("prio_fetch_inst", if_inst, 32'h0000_0513);
    if_req = 0; step();

    // Word store wrapping the address space.
    exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
    mem_req = 1; mem_we = 1; mem_width = 2; mem_addr = 32'hFFFF_FFFE; mem_wdata = 32'h1122_3344;
    wait_done(1, 12, lat);
    chk("wrap_latency", lat, 5);
    for (int k = 1; k <= 4; k++) chk("wrap_ram_a", a_log[k], exp_a[k-1]);
    chk("wrap_last_dout", d_log[4], 8'h11);
    mem_req = 0; step();

    // Word fetch stalled for three cycles at cnt=2.
    if_req = 1; if_addr = 32'h100; lat = -1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 3) begin chk("stall_ram_a", ram_a, 32'h102); rdy_in = 0; end
      if (k == 4 || k == 5) begin
        chk("stall_ram_a_held", ram_a, 32'h102);
        chk("stall_no_wr", ram_wr, 0);
      end
      if (k == 6) rdy_in = 1;
      if (if_done) begin lat = k; break; end
    end
    chk("stall_latency", lat, 9);
    chk("stall_inst", if_inst, 32'h0000_0513);
    if_req = 0; step();

    // Randomized traffic with stalls and mid-transfer request changes.
    for (int c = 0; c < 3000; c++) begin
      rdy_in = ($urandom_range(0, 7) != 0);
      if (mem_req && mem_done) begin
        if ($urandom_range(0, 1) == 1) mem_req = 0; else new_mem();
      end else if (!mem_req && $urandom_range(0, 3) == 0) begin
        new_mem();
      end else if (mem_req && m_act && m_mem && $urandom_range(0, 3) == 0) begin
        new_mem();
      end
      if (if_req && if_done) begin
        if ($urandom_range(0, 1) == 1) if_req = 0; else if_addr = rand_addr();
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end else if (if_req && m_act && !m_mem && $urandom_range(0, 3) == 0) begin
        if_addr = rand_addr();
      end
      step();
    end
    rdy_in = 1; mem_req = 0; if_req = 0;
    for (int k = 0; k < 20 && (busy || if_done || mem_done); k++) step();
    chk("drain_idle", busy, 0);
    step();

    // Reset in the middle of a word store.
    mem_req = 1; mem_we = 1; mem_width = 2; mem_addr = 32'h200; mem_wdata = 32'hCAFE_F00D;
    step();
    step();
    chk("rstmid_wr_before", ram_wr, 1);
    rst_in = 0;
    #1;
    chk("rstmid_ram_wr", ram_wr, 0);
    chk("rstmid_busy", busy, 0);
    mem_req = 0;
    @(negedge clk_in);
    #1;
    rst_in = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rstmid_no_done", mem_done, 0);
    end
    chk("rstmid_rdata_cleared", mem_rdata, 0);
    chk("rstmid_inst_cleared", if_inst, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; clock and reset ports come first.
REQ-002 clk_in  in  1  system clock; all state changes on its rising edge.
REQ-003 rst_in  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 rdy_in  in  1  global ready; 0 freezes all state.
REQ-005 if_req  in  1  instruction-fetch request, held until if_done.
REQ-006 if_addr  in  32  fetch address (word read, 4 bytes).
REQ-007 if_done  out  1  one-cycle pulse: if_inst valid.
REQ-008 if_inst  out  32  fetched word, little-endian.
REQ-009 mem_req  in  1  load/store request, held until mem_done.
REQ-010 mem_we  in  1  1 = store, 0 = load.
REQ-011 mem_width  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-012 mem_addr  in  32  load/store base address.
REQ-013 mem_wdata  in  32  store data; low n bytes used.
REQ-014 mem_done  out  1  one-cycle pulse: access complete.
REQ-015 mem_rdata  out  32  load data, zero-extended.
REQ-016 ram_din  in  8  RAM read byte; 1-cycle read latency.
REQ-017 ram_dout  out  8  RAM write byte.
REQ-018 ram_a  out  32  RAM byte address.
REQ-019 ram_wr  out  1  1 = write ram_dout to ram_a this cycle.
REQ-020 busy  out  1  1 whenever state is not IDLE; feeds the stall controller.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, READ, WRITE.
REQ-022 In IDLE with rdy_in=1, the FSM SHALL accept one request per cycle: mem_req over if_req (fixed priority).
- On accept, the FSM latches the address, width, data and owner.
- It loads n (bytes: 1/2/4) and clears the byte counter cnt.
- It moves to WRITE for a store, otherwise to READ.
REQ-023 A request whose own done is high in the current cycle SHALL be ignored, so a held req is not re-accepted.
REQ-024 Request inputs SHALL be ignored outside IDLE; changes to them mid-transfer have no effect.
REQ-025 ram_a SHALL equal latched base + cnt, modulo 2^32 (wrap-around, no fault).
REQ-026 READ SHALL last n+1 cycles (cnt = 0..n).
- At cnt = k ≥ 1, ram_din is captured into byte k-1.
- At cnt = n, the next state is IDLE.
REQ-027 WRITE SHALL last n cycles (cnt = 0..n-1).
- ram_wr = 1 and ram_dout = latched data byte cnt.
- After cnt = n-1, the next state is IDLE.
REQ-028 if_done/mem_done SHALL be registered pulses, high exactly one cycle after the last READ/WRITE cycle.
- Only the owner's done pulses.
- Read latency: accept cycle T → done in T+n+2 (word T+6, byte T+3).
- Write latency: done in T+n+1 (word T+5).
REQ-029 if_inst/mem_rdata SHALL hold their last assembled value until the next completed read for that owner; unread upper bytes are 0.
REQ-030 ram_wr SHALL be 0 in IDLE, in READ, and whenever rdy_in=0.
REQ-031 While rdy_in=0, state, cnt, data and the pending done SHALL all hold.
- ram_a holds, so a read capture resumes correctly.
- The stalled write byte is re-issued when rdy_in returns to 1.
REQ-032 Fetch during continuous mem_req SHALL starve; this is accepted behaviour, since the pipeline stalls until loads and stores finish.

Reset
REQ-033 rst_in=0 SHALL immediately (asynchronously) force the following, including mid-transfer; a partial write is abandoned:
- state to IDLE;
- cnt to 0;
- ram_wr, if_done, mem_done and busy to 0;
- ram_a, ram_dout, if_inst and mem_rdata to 0.
REQ-034 The first accept SHALL occur in the first rising edge with rst_in=1 and rdy_in=1.

Structure
REQ-035 The width encodings (BYTE/HALF/WORD) and the state encoding SHALL live in the shared defines package; the address width comes from the existing InstAddrBus definition.
REQ-036 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-037 Word fetch: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13 05 00 00.
- Required: ram_a 0x100..0x103 on consecutive cycles.
- Required: if_done at T+6 with if_inst=0x00000513.
REQ-038 Byte store: mem_we=1, width=0, addr=0x20, wdata=0xABCD12EF.
- Required: exactly one ram_wr cycle, ram_a=0x20, ram_dout=0xEF.
- Required: mem_done at T+2.
REQ-039 Simultaneous if_req and mem_req load (half, addr=0x40, RAM=34 12).
- Required: mem served first, mem_rdata=0x00001234 at T+4.
- Required: fetch accepted in the mem_done cycle +1 or later, never in the done cycle itself.
REQ-040 Word store to 0xFFFFFFFE: ram_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-041 rdy_in=0 for 3 cycles at cnt=2 of a word read.
- Required: ram_a held and no capture during the stall.
- Required: correct word, with done delayed by exactly 3 cycles.
REQ-042 Reset mid-write: rst_in=0 at cnt=1 of a word store.
- Required: ram_wr=0 and busy=0 in the same cycle.
- Required: no done pulse after release.
